// File: rtl/sfx_pkg.sv
// Shared types and clip table for the sound-effect sequencer.
// Clip table entries are indexed by sfx_t; table values never wrap the ROM.
package sfx_pkg;

   typedef enum logic [2:0] {
      SFX_NONE     = 3'd0,
      SFX_CHOMP    = 3'd1,
      SFX_EATGHOST = 3'd2,
      SFX_START    = 3'd3,
      SFX_DEATH    = 3'd4
   } sfx_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_OUT
   } seq_state_t;

   // Indexed by sfx_t: NONE, CHOMP, EATGHOST, START, DEATH
   localparam int unsigned SFX_BASE [5] = '{32'd0, 32'd16384, 32'd18432, 32'd0,     32'd22528};
   localparam int unsigned SFX_LEN  [5] = '{32'd0, 32'd2048,  32'd4096,  32'd16384, 32'd12288};

   // Higher rank wins arbitration: death > start > eatghost > chomp.
   function automatic logic [2:0] sfx_rank(input sfx_t s);
      case (s)
         SFX_DEATH:    return 3'd4;
         SFX_START:    return 3'd3;
         SFX_EATGHOST: return 3'd2;
         SFX_CHOMP:    return 3'd1;
         default:      return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/sfx_priority_encoder.sv
// Fixed-priority arbiter over the request edge pulses.
// Define SFX_PREEMPT_EN to let a strictly higher-priority request abort a playing clip.
module sfx_priority_encoder
   import sfx_pkg::*;
(
   input  logic pulse_start,
   input  logic pulse_chomp,
   input  logic pulse_eatghost,
   input  logic pulse_death,
   input  sfx_t active,
   output sfx_t winner,
   output logic take
);

   always_comb begin
      winner = SFX_NONE;
      if (pulse_death)
         winner = SFX_DEATH;
      else if (pulse_start)
         winner = SFX_START;
      else if (pulse_eatghost)
         winner = SFX_EATGHOST;
      else if (pulse_chomp)
         winner = SFX_CHOMP;
   end

   always_comb begin
      take = 1'b0;
      if (winner != SFX_NONE) begin
         if (active == SFX_NONE)
            take = 1'b1;
`ifdef SFX_PREEMPT_EN
         else if (sfx_rank(winner) > sfx_rank(active))
            take = 1'b1;
`else
         else
            take = 1'b0;
`endif
      end
   end

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: arbitrates game events, walks clip ROM ranges, feeds the codec.
// Optional build macro SFX_PREEMPT_EN enables higher-priority clip preemption.
//
// state    | meaning
// ST_IDLE  | no clip; codec fed silence every write_ready cycle
// ST_FETCH | rom_addr presented to the ROM
// ST_LOAD  | ROM data converted and registered into writedata
// ST_OUT   | current sample offered to the codec REPEAT times
module sfx_sequencer
   import sfx_pkg::*;
#(
   parameter int REPEAT = 4,
   parameter int ADDR_W = 16
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              req_start,
   input  logic              req_chomp,
   input  logic              req_eatghost,
   input  logic              req_death,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_q,
   input  logic              write_ready,
   output logic              write,
   output logic [23:0]       writedata,
   output logic              busy,
   output sfx_t              active_sfx
);

   localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT - 1);

   seq_state_t        state, state_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [ADDR_W-1:0] end_addr, end_nxt;
   logic [REP_W-1:0]  rep, rep_nxt;
   logic [23:0]       data_nxt;
   sfx_t              active_nxt;

   logic [3:0]        req_now, req_q, pulses;
   logic              primed;
   sfx_t              winner;
   logic              take;
   logic [ADDR_W-1:0] clip_base, clip_end;
   logic              sample_valid;

   // primed keeps a level held across reset release from looking like a new edge
   assign req_now = {req_death, req_start, req_eatghost, req_chomp};
   assign pulses  = req_now & ~req_q & {4{primed}};

   sfx_priority_encoder u_prio (
      .pulse_start    (pulses[2]),
      .pulse_chomp    (pulses[0]),
      .pulse_eatghost (pulses[1]),
      .pulse_death    (pulses[3]),
      .active         (active_sfx),
      .winner         (winner),
      .take           (take)
   );

   assign clip_base = ADDR_W'(SFX_BASE[winner]);
   assign clip_end  = clip_base + ADDR_W'(SFX_LEN[winner]) - ADDR_W'(1);

   assign sample_valid = (state == ST_IDLE) || (state == ST_OUT);
   assign write        = write_ready & sample_valid;
   assign busy         = (state != ST_IDLE);

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         rom_addr   <= '0;
         end_addr   <= '0;
         rep        <= '0;
         writedata  <= '0;
         active_sfx <= SFX_NONE;
         req_q      <= '0;
         primed     <= 1'b0;
      end else begin
         state      <= state_nxt;
         rom_addr   <= addr_nxt;
         end_addr   <= end_nxt;
         rep        <= rep_nxt;
         writedata  <= data_nxt;
         active_sfx <= active_nxt;
         req_q      <= req_now;
         primed     <= 1'b1;
      end
   end

   always_comb begin
      state_nxt  = state;
      addr_nxt   = rom_addr;
      end_nxt    = end_addr;
      rep_nxt    = rep;
      data_nxt   = writedata;
      active_nxt = active_sfx;

      // A taken request restarts from FETCH whatever the current state.
      if (take) begin
         addr_nxt   = clip_base;
         end_nxt    = clip_end;
         rep_nxt    = '0;
         active_nxt = winner;
         state_nxt  = ST_FETCH;
      end else begin
         case (state)
            ST_IDLE: begin
               data_nxt = '0;
            end
            ST_FETCH: begin
               state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
               data_nxt  = {rom_q ^ 8'h80, 16'h0000};
               rep_nxt   = '0;
               state_nxt = ST_OUT;
            end
            ST_OUT: begin
               if (write) begin
                  if (rep != REP_LAST) begin
                     rep_nxt = rep + REP_W'(1);
                  end else if (rom_addr == end_addr) begin
                     data_nxt   = '0;
                     active_nxt = SFX_NONE;
                     state_nxt  = ST_IDLE;
                  end else begin
                     addr_nxt  = rom_addr + ADDR_W'(1);
                     state_nxt = ST_FETCH;
                  end
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: transaction-level model predicts every codec write.
// Behaviour under SFX_PREEMPT_EN follows the same macro as the design.
module tb_sfx_sequencer;
   import sfx_pkg::*;

   localparam int REPEAT = 4;
   localparam int ADDR_W = 16;
`ifdef SFX_PREEMPT_EN
   localparam bit PREEMPT = 1'b1;
`else
   localparam bit PREEMPT = 1'b0;
`endif

   typedef struct packed {
      logic [15:0] addr;
      logic [23:0] data;
   } exp_t;

   logic              CLOCK_50 = 1'b0;
   logic              reset = 1'b1;
   logic              req_start = 1'b0;
   logic              req_chomp = 1'b0;
   logic              req_eatghost = 1'b0;
   logic              req_death = 1'b0;
   logic [ADDR_W-1:0] rom_addr;
   logic [7:0]        rom_q = 8'h00;
   logic              write_ready = 1'b1;
   logic              write;
   logic [23:0]       writedata;
   logic              busy;
   sfx_t              active_sfx;

   int n_checks = 0;
   int n_fail = 0;

   exp_t       m_q[$];
   sfx_t       m_active = SFX_NONE;
   bit         m_armed = 1'b0;
   logic [3:0] m_prev = '0;
   logic [3:0] m_lv;
   sfx_t       m_win;
   exp_t       m_e;
   int         n;

   always #10 CLOCK_50 = ~CLOCK_50;

   // ROM content is the low address byte, one-cycle registered read
   always @(posedge CLOCK_50) rom_q <= rom_addr[7:0];

   sfx_sequencer #(.REPEAT(REPEAT), .ADDR_W(ADDR_W)) dut (
      .CLOCK_50     (CLOCK_50),
      .reset        (reset),
      .req_start    (req_start),
      .req_chomp    (req_chomp),
      .req_eatghost (req_eatghost),
      .req_death    (req_death),
      .rom_addr     (rom_addr),
      .rom_q        (rom_q),
      .write_ready  (write_ready),
      .write        (write),
      .writedata    (writedata),
      .busy         (busy),
      .active_sfx   (active_sfx)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   function automatic int rank(input sfx_t s);
      case (s)
         SFX_DEATH:    return 4;
         SFX_START:    return 3;
         SFX_EATGHOST: return 2;
         SFX_CHOMP:    return 1;
         default:      return 0;
      endcase
   endfunction

   // edges bit order: death, start, eatghost, chomp
   function automatic sfx_t pick(input logic [3:0] e);
      if (e[3]) return SFX_DEATH;
      if (e[2]) return SFX_START;
      if (e[1]) return SFX_EATGHOST;
      if (e[0]) return SFX_CHOMP;
      return SFX_NONE;
   endfunction

   task automatic load_clip(input sfx_t s);
      int   base;
      int   len;
      exp_t x;
      case (s)
         SFX_START:    begin base = 0;     len = 16384; end
         SFX_CHOMP:    begin base = 16384; len = 2048;  end
         SFX_EATGHOST: begin base = 18432; len = 4096;  end
         SFX_DEATH:    begin base = 22528; len = 12288; end
         default:      begin base = 0;     len = 0;     end
      endcase
      m_q.delete();
      for (int a = base; a < base + len; a++) begin
         for (int r = 0; r < REPEAT; r++) begin
            x.addr = 16'(a);
            x.data = {8'(a) ^ 8'h80, 16'h0000};
            m_q.push_back(x);
         end
      end
      m_active = s;
   endtask

   // Arbitration model: decide on the levels seen at each clock edge
   always @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         m_q.delete();
         m_active = SFX_NONE;
         m_armed  = 1'b0;
         m_prev   = '0;
      end else begin
         m_lv  = {req_death, req_start, req_eatghost, req_chomp};
         m_win = m_armed ? pick(m_lv & ~m_prev) : SFX_NONE;
         if (m_win != SFX_NONE &&
             (m_active == SFX_NONE || (PREEMPT && rank(m_win) > rank(m_active))))
            load_clip(m_win);
         else if (m_q.size() == 0)
            m_active = SFX_NONE;
         m_prev  = m_lv;
         m_armed = 1'b1;
      end
   end

   // Write scoreboard, sampled away from the active edge
   always @(negedge CLOCK_50) begin
      if (!reset) begin
         chk("busy", busy, m_active != SFX_NONE);
         chk("active", active_sfx, m_active);
         chk("write_gate", write & ~write_ready, 0);
         if (m_active == SFX_NONE)
            chk("idle_write", write, write_ready);
         if (write) begin
            if (m_q.size() == 0) begin
               chk("silence", writedata, 0);
            end else begin
               m_e = m_q.pop_front();
               chk("clip_data", writedata, m_e.data);
               chk("clip_addr", rom_addr, m_e.addr);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired got=running exp=finished");
      n_fail++;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      reset = 1'b0;
      repeat (4) tick();
      @(negedge CLOCK_50);
      chk("rst_write", write, 1);
      chk("rst_data", writedata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_addr", rom_addr, 0);
      chk("rst_active", active_sfx, SFX_NONE);

      // Full chomp clip with the codec always ready
      tick(); req_chomp = 1'b1;
      tick(); req_chomp = 1'b0;
      @(negedge CLOCK_50);
      chk("chomp_fetch_wr", write, 0);
      chk("chomp_fetch_addr", rom_addr, 16384);
      @(negedge CLOCK_50);
      chk("chomp_load_wr", write, 0);
      @(negedge CLOCK_50);
      chk("chomp_first_wr", write, 1);
      chk("chomp_first_data", writedata, 24'h800000);
      n = 2;
      do begin
         @(negedge CLOCK_50);
         n++;
      end while (busy && n < 20000);
      chk("chomp_len", n, 2048 * 6);
      chk("chomp_tail", writedata, 0);

      // Same-cycle eatghost and chomp, sparse codec readiness
      tick(); req_eatghost = 1'b1; req_chomp = 1'b1;
      tick(); req_eatghost = 1'b0; req_chomp = 1'b0;
      @(negedge CLOCK_50);
      chk("same_active", active_sfx, SFX_EATGHOST);
      chk("same_addr", rom_addr, 18432);
      for (int c = 0; c < 2000; c++) begin
         tick();
         write_ready = ($urandom_range(0, 7) == 0);
         req_chomp   = ($urandom_range(0, 15) == 0);
      end
      req_chomp = 1'b0;
      tick(); reset = 1'b1;
      tick(); reset = 1'b0; write_ready = 1'b1;
      repeat (3) tick();

      // Death arriving mid-start
      req_start = 1'b1;
      tick(); req_start = 1'b0;
      for (int c = 0; c < 5000 && rom_addr != 16'd100; c++) begin
         tick();
         write_ready = $urandom_range(0, 1) == 1;
      end
      chk("start_reach", rom_addr, 100);
      write_ready = 1'b1;
      req_death = 1'b1;
      tick(); req_death = 1'b0;
      @(negedge CLOCK_50);
      chk("death_active", active_sfx, PREEMPT ? SFX_DEATH : SFX_START);
      chk("death_addr", rom_addr == 16'd22528, PREEMPT);
      for (int c = 0; c < 1500; c++) begin
         tick();
         write_ready = $urandom_range(0, 3) != 0;
         req_death   = ($urandom_range(0, 30) == 0);
         req_start   = ($urandom_range(0, 30) == 0);
      end
      req_death = 1'b0; req_start = 1'b0;
      tick(); reset = 1'b1;
      tick(); reset = 1'b0;
      repeat (3) tick();

      // Reset mid-death with the request level held through release
      req_death = 1'b1;
      tick();
      for (int c = 0; c < 300; c++) begin
         tick();
         write_ready = $urandom_range(0, 1) == 1;
      end
      chk("death_playing", busy, 1);
      reset = 1'b1;
      #1;
      chk("rst_busy_now", busy, 0);
      chk("rst_data_now", writedata, 0);
      tick(); reset = 1'b0; write_ready = 1'b1;
      repeat (20) tick();
      @(negedge CLOCK_50);
      chk("no_retrig", busy, 0);
      req_death = 1'b0;
      tick(); tick();
      req_chomp = 1'b1;
      tick(); req_chomp = 1'b0;
      @(negedge CLOCK_50);
      chk("restart_active", active_sfx, SFX_CHOMP);
      chk("restart_addr", rom_addr, 16384);

      // Random event traffic
      for (int c = 0; c < 3000; c++) begin
         tick();
         write_ready  = $urandom_range(0, 3) != 0;
         req_chomp    = req_chomp    ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 59) == 0);
         req_eatghost = req_eatghost ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 59) == 0);
         req_start    = req_start    ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 89) == 0);
         req_death    = req_death    ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 119) == 0);
      end
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Sound-effect sequencer and arbiter between the game logic and the audio codec. It accepts one-cycle or level game-event requests (start, chomp, eat-ghost, death) and selects one clip by fixed priority. It walks that clip's address range in the shared 8-bit sample ROM, paced by the codec's `write_ready` handshake, and drives the 24-bit sample and `write` strobe into the codec. Outside a clip it keeps the codec fed with silence.

## Interface
- `REPEAT`, 4: codec writes per ROM sample (48 kHz codec / 12 kHz clips); must be ≥1.
- `ADDR_W`, 16: ROM address width.

- `CLOCK_50` in 1: system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_start`, `req_chomp`, `req_eatghost`, `req_death` in 1 each: event requests; the rising edge is what counts.
- `rom_addr` out ADDR_W: ROM address; the ROM has 1-cycle registered read latency.
- `rom_q` in 8: ROM data, unsigned offset-binary.
- `write_ready` in 1: codec DAC FIFO has room.
- `write` out 1: sample accepted this cycle; combinational, equals `write_ready & sample_valid`.
- `writedata` out 24: sample to the codec, same value on left and right.
- `busy` out 1: a clip is playing.
- `active_sfx` out 3: `sfx_t` code of the playing clip, `SFX_NONE` when idle.

## Operation
- Priority, high to low: death > start > eatghost > chomp. Same-cycle requests: the highest wins and the others are dropped.
- Requests are rising-edge detected from a registered copy of each input. A held level never retriggers. The edge registers reset to 0.
- Sample conversion: `writedata = {rom_q ^ 8'h80, 16'h0000}`, i.e. signed and MSB-aligned. Silence is 24'h0.
- States:
  - IDLE: `sample_valid`=1, `writedata`=0, `busy`=0. On a winning request, load `rom_addr`←base, clear `end_addr`/`rep` as needed, set `active_sfx`, go to FETCH.
  - FETCH: `sample_valid`=0; the address is presented to the ROM. Go to LOAD.
  - LOAD: `sample_valid`=0; register the converted `rom_q` into `writedata`, `rep`←0. Go to OUT.
  - OUT: `sample_valid`=1. On each accept (`write`=1):
    - If `rep`<REPEAT-1: `rep`++ and stay in OUT.
    - Else if `rom_addr`==base+len-1: go to IDLE, `writedata`←0, `active_sfx`←NONE.
    - Else: `rom_addr`++ and go to FETCH.
- Clip base and length come from the package table, indexed by `sfx_t`. The end address is base+len-1, computed in ADDR_W bits. The table never wraps past 2^ADDR_W.
- A request during FETCH, LOAD or OUT is handled per Configuration. A request of equal or lower priority to the active clip is always dropped, and it does not restart the clip.

## Timing
- Reset values: `rom_addr`=0, `writedata`=0, `busy`=0, `active_sfx`=NONE, state IDLE. Because IDLE has `sample_valid`=1, `write` follows `write_ready` immediately after reset.
- Latency from request edge to the first clip sample on `writedata`: request cycle → IDLE decision registered (+1) → FETCH (+1) → LOAD (+1). OUT is entered 3 cycles after the request was high. Edge detection adds 0 cycles, because the request is compared against its previous-cycle copy.
- Each new ROM sample costs 2 cycles in which `write`=0 regardless of `write_ready`.
- An accept on the last repeat of the last sample returns the block to IDLE on the next edge. That silence word is writable in the same cycle that IDLE begins.
- Asserting `reset` mid-clip forces IDLE asynchronously. No partial sample is written after reset.

## Configuration
- `SFX_PREEMPT_EN` defined: a strictly higher-priority request in any non-IDLE state aborts the current clip. The abort is taken from the current state, not after finishing the sample. It loads the new base and enters FETCH; the in-flight `rep` count is discarded.
- `SFX_PREEMPT_EN` undefined: all requests outside IDLE are dropped, and a clip always plays to its end.

## Structure
- Package `sfx_pkg` holds:
  - `typedef enum logic [2:0] sfx_t` = NONE=0, CHOMP=1, EATGHOST=2, START=3, DEATH=4.
  - Constant arrays `SFX_BASE` and `SFX_LEN`: START 0/16384, CHOMP 16384/2048, EATGHOST 18432/4096, DEATH 22528/12288.
  - The state enum.
- Sub-module `sfx_priority_encoder`: combinational. Takes the four edge pulses and the current `active_sfx`, and returns the winning `sfx_t` (or NONE) plus a `take` flag. It contains the preempt gating.

## Test plan
- After reset with `write_ready`=1 constant: `write`=1 every cycle, `writedata`=0, `busy`=0, `rom_addr`=0.
- Pulse `req_chomp` with ROM = address[7:0] and `write_ready`=1:
  - `rom_addr` steps 16384..18431.
  - Each sample is written exactly 4 times.
  - The first `writedata` is {8'h00^8'h80,16'h0}=24'h800000.
  - `busy` drops after 2048×6 cycles and `writedata` returns to 0.
- `req_eatghost` and `req_chomp` high in the same cycle: `active_sfx`=EATGHOST and `rom_addr`=18432 in FETCH. Chomp never plays.
- With `SFX_PREEMPT_EN`, `req_death` mid-START (address 100): the next FETCH is at 22528 and `active_sfx`=DEATH. Without the macro: START completes to address 16383 and death is ignored.
- `write_ready` toggling 1-of-8 cycles: each sample still gets exactly REPEAT accepts, and `writedata` holds stable while `write_ready`=0.
- Assert `reset` for 1 cycle mid-DEATH: `busy`=0 and `writedata`=0 immediately. A later `req_chomp` starts cleanly at 16384. A `req_death` held high through reset release does not retrigger.
